// File: rtl/result_checker_if.sv
// Result/expected FIFO read-side bundle for result_checker (show-ahead FIFOs).
interface result_checker_if #(
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5
);
  logic [RTF_WIDTH+CYCLE_RANGE:0] rfifo_dataq;
  logic                           rfifo_rdempty;
  logic                           rfifo_rdreq;
  logic [2*RTF_WIDTH-1:0]         efifo_dataq;
  logic                           efifo_rdempty;
  logic                           efifo_rdreq;

  modport master (
    input  rfifo_dataq, rfifo_rdempty, efifo_dataq, efifo_rdempty,
    output rfifo_rdreq, efifo_rdreq
  );

  modport slave (
    output rfifo_dataq, rfifo_rdempty, efifo_dataq, efifo_rdempty,
    input  rfifo_rdreq, efifo_rdreq
  );
endinterface

// File: rtl/result_checker.sv
// Compares popped result words against masked expected words, one vector per clock.
// Define RESULT_CHECKER_ABORT_EN to stop the run at the first failing vector.
module result_checker #(
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   vec_count,
  result_checker_if.master       fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [CNT_WIDTH-1:0]   fail_count,
  output logic [CNT_WIDTH-1:0]   first_fail_idx,
  output logic [RTF_WIDTH-1:0]   first_fail_data,
  output logic [CYCLE_RANGE:0]   first_fail_cycles
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] vec_q;
  logic [CNT_WIDTH-1:0] idx_q;
  logic [IDLE_W-1:0]    idle_q;
  logic [IDLE_W-1:0]    idle_nxt;

  logic [RTF_WIDTH-1:0] r_data;
  logic [CYCLE_RANGE:0] r_cyc;
  logic [RTF_WIDTH-1:0] e_value;
  logic [RTF_WIDTH-1:0] e_mask;
  logic                 pop;
  logic                 mismatch;
  logic                 last_pop;
  logic                 idle_hit;
  logic                 abort_hit;
  logic                 launch;

  assign r_data   = fifo.rfifo_dataq[RTF_WIDTH-1:0];
  assign r_cyc    = fifo.rfifo_dataq[RTF_WIDTH+CYCLE_RANGE:RTF_WIDTH];
  assign e_value  = fifo.efifo_dataq[RTF_WIDTH-1:0];
  assign e_mask   = fifo.efifo_dataq[2*RTF_WIDTH-1:RTF_WIDTH];

  // Both FIFOs are popped together or not at all.
  assign pop      = (state_q == S_WAIT) && !fifo.rfifo_rdempty && !fifo.efifo_rdempty
                    && (idx_q < vec_q);
  assign mismatch = |((r_data ^ e_value) & e_mask);
  assign last_pop = pop && ((idx_q + CNT_WIDTH'(1)) == vec_q);
  assign idle_nxt = idle_q + IDLE_W'(1);
  assign idle_hit = !pop && (idx_q != vec_q) && (idle_nxt == IDLE_W'(TIMEOUT));
  assign launch   = start && (state_q != S_WAIT);

`ifdef RESULT_CHECKER_ABORT_EN
  assign abort_hit = pop && mismatch;
`else
  assign abort_hit = 1'b0;
`endif

  assign fifo.rfifo_rdreq = pop;
  assign fifo.efifo_rdreq = pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    pass    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: begin
        busy = 1'b1;
        // Leave on the edge that ends the final pop so DONE follows it directly.
        if ((idx_q == vec_q) || last_pop || idle_hit || abort_hit) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (fail_count == '0) && !timeout;
        if (start) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vec_q             <= '0;
      idx_q             <= '0;
      idle_q            <= '0;
      timeout           <= 1'b0;
      fail_count        <= '0;
      first_fail_idx    <= '0;
      first_fail_data   <= '0;
      first_fail_cycles <= '0;
    end else if (launch) begin
      vec_q             <= vec_count;
      idx_q             <= '0;
      idle_q            <= '0;
      timeout           <= 1'b0;
      fail_count        <= '0;
      first_fail_idx    <= '0;
      first_fail_data   <= '0;
      first_fail_cycles <= '0;
    end else if (state_q == S_WAIT) begin
      if (pop) begin
        idx_q  <= idx_q + CNT_WIDTH'(1);
        idle_q <= '0;
        if (mismatch) begin
          if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
          if (fail_count == '0) begin
            first_fail_idx    <= idx_q;
            first_fail_data   <= r_data;
            first_fail_cycles <= r_cyc;
          end
        end
      end else begin
        idle_q <= idle_nxt;
        if (idle_hit) timeout <= 1'b1;
      end
    end
  end

endmodule
